// File: rtl/tx4p_fifo_push_pkg.sv
// Shared definitions for the four-phase push transmitter and its receiver.
package tx4p_fifo_push_pkg;

  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/tx4p_fifo_push_sync_chain.sv
// Single-bit multi-flop synchroniser for a level crossing into clk.
// Shared with the matching receiver, which uses it on req.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] flops;

  // Shift the asynchronous level through the chain; all flops clear on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flops <= '0;
    else        flops <= {flops[STAGES-2:0], d};
  end

  assign q = flops[STAGES-1];

endmodule

// File: rtl/tx4p_fifo_push.sv
// Buffered four-phase push transmitter: words from the local core are queued
// in a small FIFO and sent one at a time over a req/ack handshake.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no word in flight; launch the FIFO head once ack_s is low
// ST_REQ  | req high with output_tx stable; waiting for ack_s to rise
// ST_WAIT | req dropped; waiting for ack_s to return low
module tx4p_fifo_push
  import tx4p_fifo_push_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              v,
  input  logic [DATA_W-1:0] input_tx,
  output logic              ready,
  input  logic              ack,
  output logic              req,
  output logic [DATA_W-1:0] output_tx,
  output logic              f,
  output logic              busy,
  output logic              ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;
  logic              ack_s;
  logic              ack_d;
  logic              req_nxt;
  state_t            state;
  state_t            state_nxt;

  // Ready comes from the registered count only, so a pop never frees a slot
  // for a push in the same cycle.
  assign ready = (count != CW'(DEPTH));
  assign push  = v & ready;
  assign busy  = (count != '0) | (state != ST_IDLE);

  sync_chain #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ack),
    .q     (ack_s)
  );

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= input_tx;
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (v & ~ready) ovf <= 1'b1;
    end
  end

  // Handshake next-state logic; a launch pops the head into output_tx.
  always_comb begin
    state_nxt = state;
    req_nxt   = req;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((count != '0) && !ack_s) begin
          pop       = 1'b1;
          req_nxt   = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack_s) begin
          req_nxt   = 1'b0;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!ack_s) state_nxt = ST_IDLE;
      end
      default: begin
        req_nxt   = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, registered req/output_tx, and the completion pulse, which is
  // gated by ST_REQ so an ack still high out of reset cannot fire it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      req       <= 1'b0;
      output_tx <= '0;
      ack_d     <= 1'b0;
      f         <= 1'b0;
    end else begin
      state <= state_nxt;
      req   <= req_nxt;
      if (pop) output_tx <= mem[rd_ptr];
      ack_d <= ack_s;
      f     <= ack_s & ~ack_d & (state == ST_REQ);
    end
  end

endmodule

// File: tb/tb_tx4p_fifo_push.sv
// Directed bench for tx4p_fifo_push with DATA_W=8, DEPTH=4, SYNC_STAGES=2.
module tb_tx4p_fifo_push;

  logic       clk;
  logic       reset;
  logic       v;
  logic [7:0] input_tx;
  logic       ready;
  logic       ack;
  logic       req;
  logic [7:0] output_tx;
  logic       f;
  logic       busy;
  logic       ovf;

  int total = 0;
  int bad   = 0;
  int f_cnt = 0;

  tx4p_fifo_push #(.DATA_W(8), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .v         (v),
    .input_tx  (input_tx),
    .ready     (ready),
    .ack       (ack),
    .req       (req),
    .output_tx (output_tx),
    .f         (f),
    .busy      (busy),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count completion pulses, sampled mid-cycle.
  always @(negedge clk) if (f === 1'b1) f_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    v        = 1'b1;
    input_tx = w;
    tick();
    v        = 1'b0;
  endtask

  // Complete one handshake as the remote side, checking the delivered word.
  task automatic handshake(input logic [7:0] exp_w, input string tag);
    int n;
    n = 0;
    while (req !== 1'b1 && n < 30) begin tick(); n++; end
    chk({tag, "_req_up"}, 32'(req), 32'd1);
    chk({tag, "_data"}, 32'(output_tx), 32'(exp_w));
    ack = 1'b1;
    n = 0;
    while (req !== 1'b0 && n < 30) begin tick(); n++; end
    chk({tag, "_req_dn"}, 32'(req), 32'd0);
    ack = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] w;
    int         nd;

    reset = 1'b0; ack = 1'b0; v = 1'b0; input_tx = 8'h00;
    repeat (2) tick();
    chk("rst_req",   32'(req),       32'd0);
    chk("rst_data",  32'(output_tx), 32'd0);
    chk("rst_f",     32'(f),         32'd0);
    chk("rst_ovf",   32'(ovf),       32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_ready", 32'(ready),     32'd1);
    reset = 1'b1;
    tick();

    // Single word: launch one edge after the push, ack latency of 3 edges.
    push_word(8'hA5);
    chk("t1_busy_after_push", 32'(busy), 32'd1);
    chk("t1_no_bypass",       32'(req),  32'd0);
    tick();
    chk("t1_req",  32'(req),       32'd1);
    chk("t1_data", 32'(output_tx), 32'hA5);
    ack = 1'b1;
    tick(); tick();
    chk("t1_req_held", 32'(req), 32'd1);
    chk("t1_f_early",  32'(f),   32'd0);
    tick();
    chk("t1_req_fall", 32'(req), 32'd0);
    chk("t1_f_pulse",  32'(f),   32'd1);
    tick();
    chk("t1_f_one_cycle", 32'(f), 32'd0);
    ack = 1'b0;
    tick(); tick();
    chk("t1_busy_wait", 32'(busy), 32'd1);
    tick();
    chk("t1_busy_idle", 32'(busy), 32'd0);

    // Burst of 4 while the remote holds ack high.
    ack = 1'b1;
    repeat (3) tick();
    f_cnt = 0;
    push_word(8'h01); push_word(8'h02); push_word(8'h03); push_word(8'h04);
    chk("t2_ready_full", 32'(ready), 32'd0);
    chk("t2_req_held",   32'(req),   32'd0);
    ack = 1'b0;
    handshake(8'h01, "t2_w1");
    handshake(8'h02, "t2_w2");
    handshake(8'h03, "t2_w3");
    handshake(8'h04, "t2_w4");
    chk("t2_f_count", 32'(f_cnt), 32'd4);
    chk("t2_idle",    32'(busy),  32'd0);

    // Overflow: a push into a full FIFO is dropped and ovf sticks.
    ack = 1'b1;
    repeat (3) tick();
    push_word(8'h11); push_word(8'h12); push_word(8'h13); push_word(8'h14);
    chk("t3_ready_full", 32'(ready), 32'd0);
    push_word(8'h55);
    chk("t3_ovf_set",   32'(ovf),   32'd1);
    chk("t3_ready_low", 32'(ready), 32'd0);
    ack = 1'b0;
    handshake(8'h11, "t3_w1");
    handshake(8'h12, "t3_w2");
    handshake(8'h13, "t3_w3");
    handshake(8'h14, "t3_w4");
    repeat (5) tick();
    chk("t3_dropped_not_sent", 32'(req),  32'd0);
    chk("t3_busy",             32'(busy), 32'd0);
    chk("t3_ovf_sticky",       32'(ovf),  32'd1);

    // ack high across reset release: nothing launches until it drops.
    ack   = 1'b1;
    reset = 1'b0;
    tick();
    chk("t4_ovf_cleared", 32'(ovf), 32'd0);
    reset = 1'b1;
    tick(); tick();
    push_word(8'h10);
    repeat (4) tick();
    chk("t4_req_blocked", 32'(req),  32'd0);
    chk("t4_busy",        32'(busy), 32'd1);
    ack = 1'b0;
    tick(); tick();
    chk("t4_req_still_low", 32'(req), 32'd0);
    tick();
    chk("t4_req_rise", 32'(req),       32'd1);
    chk("t4_data",     32'(output_tx), 32'h10);
    handshake(8'h10, "t4_w");

    // Reset mid-handshake with two words queued.
    push_word(8'h21); push_word(8'h22); push_word(8'h23);
    chk("t5_req_up",   32'(req),   32'd1);
    chk("t5_data",     32'(output_tx), 32'h21);
    #2 reset = 1'b0;
    #1;
    chk("t5_async_req",   32'(req),   32'd0);
    chk("t5_async_busy",  32'(busy),  32'd0);
    chk("t5_async_ready", 32'(ready), 32'd1);
    chk("t5_async_ovf",   32'(ovf),   32'd0);
    #1 reset = 1'b1;
    tick();
    push_word(8'h77);
    handshake(8'h77, "t5_after");
    repeat (4) tick();
    chk("t5_queue_lost", 32'(busy), 32'd0);

    // Pointer wrap: 10 words with interleaved pushes and handshakes.
    f_cnt = 0;
    nd    = 0;
    for (int k = 0; k < 10; k++) begin
      while (ready !== 1'b1 && q.size() > 0) begin
        w = q.pop_front();
        handshake(w, "t6_w");
        nd++;
      end
      w = 8'h30 + 8'(k);
      push_word(w);
      q.push_back(w);
      if (k % 2 == 1) begin
        w = q.pop_front();
        handshake(w, "t6_w");
        nd++;
      end
    end
    while (q.size() > 0) begin
      w = q.pop_front();
      handshake(w, "t6_w");
      nd++;
    end
    chk("t6_delivered", 32'(nd),    32'd10);
    chk("t6_f_count",   32'(f_cnt), 32'd10);
    chk("t6_ovf",       32'(ovf),   32'd0);
    chk("t6_busy",      32'(busy),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
